// File: rtl/eth_tx_stream_arb.sv
// Two-source round-robin frame arbiter for the 10-bit {CKE,FRM,DAT[7:0]} Ethernet TX stream.
// Define ETH_TX_ARB_TIMEOUT_EN to abandon a grant whose source never starts its frame.
module eth_tx_stream_arb #(
  parameter int IFG_TICKS     = 12,
  parameter int START_TIMEOUT = 1024,
  parameter int TO_W          = 11
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_tick,
  input  logic       i_req0,
  input  logic       i_req1,
  output logic       o_go0,
  output logic       o_go1,
  input  logic [9:0] i_in_stream0,
  input  logic [9:0] i_in_stream1,
  output logic [9:0] o_out_eth_stream,
  output logic       o_busy,
  output logic       o_grant_id,
  output logic       o_timeout_err
);

  localparam int GAP_W = (IFG_TICKS > 0) ? $clog2(IFG_TICKS + 1) : 1;
  localparam logic [GAP_W-1:0] GAP_MAX  = GAP_W'(IFG_TICKS);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(IFG_TICKS - 1);

  if (TO_W < 31 && (1 << TO_W) <= START_TIMEOUT) begin : g_to_w_check
    $error("eth_tx_stream_arb: TO_W too narrow for START_TIMEOUT");
  end

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_FRAME = 2'd2,
    ST_GAP   = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_last;
  logic             r_grant_id;
  logic             r_go0;
  logic             r_go1;
  logic [9:0]       r_out;
  logic [GAP_W-1:0] r_gap_cnt;

  logic [9:0]       w_sel_stream;
  logic             w_sel_cke;
  logic             w_sel_frm;
  logic             w_frame_start;
  logic             w_frame_end;
  logic             w_req_any;
  logic             w_winner;
  logic             w_do_grant;
  logic             w_gap_done;
  logic             w_to_expire;
  logic             w_busy;

  // Only the granted source is ever looked at; FRM on the other one is ignored.
  assign w_sel_stream  = r_grant_id ? i_in_stream1 : i_in_stream0;
  assign w_sel_cke     = w_sel_stream[9];
  assign w_sel_frm     = w_sel_stream[8];
  assign w_frame_start = w_sel_cke & w_sel_frm;
  assign w_frame_end   = w_sel_cke & ~w_sel_frm;

  assign w_req_any  = i_req0 | i_req1;
  assign w_winner   = (i_req0 & i_req1) ? ~r_last : i_req1;
  assign w_do_grant = (r_state == ST_IDLE) & w_req_any;
  assign w_gap_done = i_tick & (r_gap_cnt >= GAP_LAST);

  // State register.
  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before the edge, independent of statement order.
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    // NOTE: the default assignment first means every path assigns w_state_nxt,
    // so no latch is inferred.
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_req_any) w_state_nxt = ST_START;
      ST_START: begin
        if (w_frame_start)    w_state_nxt = ST_FRAME;
        else if (w_to_expire) w_state_nxt = ST_IDLE;
      end
      ST_FRAME: if (w_frame_end) w_state_nxt = ST_GAP;
      ST_GAP:   if (w_gap_done)  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Outputs decoded from state.
  always_comb begin
    w_busy = 1'b0;
    if (r_state != ST_IDLE) w_busy = 1'b1;
  end

  // Gap counter is held at zero outside GAP, so it is clear on entry.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_gap_cnt <= '0;
    end else if (r_state != ST_GAP) begin
      r_gap_cnt <= '0;
    end else if (i_tick && (r_gap_cnt != GAP_MAX)) begin
      r_gap_cnt <= r_gap_cnt + GAP_W'(1);
    end
  end

  // Grant pulses, round-robin pointer and the registered output mux.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_go0      <= 1'b0;
      r_go1      <= 1'b0;
      r_grant_id <= 1'b0;
      r_last     <= 1'b1;
      r_out      <= 10'h000;
    end else begin
      r_go0 <= w_do_grant & ~w_winner;
      r_go1 <= w_do_grant & w_winner;
      if (w_do_grant) begin
        r_grant_id <= w_winner;
        r_last     <= w_winner;
      end
      if ((r_state == ST_START) || (r_state == ST_FRAME)) begin
        r_out <= w_sel_stream;
      end else begin
        r_out <= {i_tick, 1'b0, 8'h00};
      end
    end
  end

`ifdef ETH_TX_ARB_TIMEOUT_EN
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(START_TIMEOUT - 1);

  logic [TO_W-1:0] r_to_cnt;
  logic            r_timeout_err;

  // A frame start in the final allowed cycle still wins over the timeout.
  assign w_to_expire = (r_state == ST_START) & ~w_frame_start & (r_to_cnt >= TO_LAST);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_to_cnt      <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      r_timeout_err <= w_to_expire;
      if (r_state != ST_START) begin
        r_to_cnt <= '0;
      end else if (r_to_cnt != TO_LAST) begin
        r_to_cnt <= r_to_cnt + TO_W'(1);
      end
    end
  end

  assign o_timeout_err = r_timeout_err;
`else
  assign w_to_expire   = 1'b0;
  assign o_timeout_err = 1'b0;
`endif

  assign o_go0            = r_go0;
  assign o_go1            = r_go1;
  assign o_out_eth_stream = r_out;
  assign o_busy           = w_busy;
  assign o_grant_id       = r_grant_id;

endmodule
